program_sequencer: RTL and testbench
====================================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, with ports Clock and Resetn.
REQ-002 Clock  in  1  rising-edge clock shared with the processor.
REQ-003 Resetn  in  1  asynchronous active-low reset.
REQ-004 Start  in  1  begin program execution from address 0; honoured only in IDLE or HALT.
REQ-005 Done_in  in  1  instruction-complete pulse from the processor's Done output.
REQ-006 rom_data  in  16  synchronous ROM read data, valid one cycle after rom_addr is driven.
REQ-007 rom_addr  out  5  ROM word address.
REQ-008 DIN  out  16  instruction/immediate word driven to the processor's DIN.
REQ-009 Run  out  1  one-cycle instruction-issue strobe to the processor.
REQ-010 Busy  out  1  high in every state except IDLE and HALT.
REQ-011 Halted  out  1  high only in HALT.

Function
REQ-012 The FSM SHALL have the states IDLE, FETCH, DECODE, RUN, IMM, WAIT and HALT, plus ERROR under REQ-025.
REQ-013 IDLE/HALT, Start=1: PC<=0, next state FETCH; otherwise the FSM SHALL remain in the current state.
REQ-014 FETCH: rom_addr=PC; next state DECODE.
REQ-015 DECODE: din_q<=rom_data; if rom_data[8:6]==3'b111 (halt), the FSM SHALL go to HALT with no Run pulse; otherwise it SHALL go to RUN.
REQ-016 DECODE with opcode 3'b001 (mvi): rom_addr=PC+1 (mod 32), so the immediate is valid in RUN.
REQ-017 RUN: Run=1 for exactly one cycle and DIN=din_q; for mvi, imm_q<=rom_data; next state IMM if mvi, else WAIT.
REQ-018 IMM: DIN=imm_q; Run=0; next state WAIT, or FETCH if Done_in=1 in this cycle.
REQ-019 WAIT: DIN SHALL hold its last value; Done_in=1 SHALL cause PC<=PC+2 for mvi or PC+1 otherwise (mod 32), with next state FETCH.
REQ-020 PC arithmetic SHALL be 5-bit and wrap from 31 to 0; an mvi at address 31 SHALL take its immediate from address 0.
REQ-021 Done_in outside IMM/WAIT SHALL be ignored; Start while Busy SHALL be ignored.
REQ-022 rom_addr SHALL equal PC in all states except DECODE-with-mvi.
REQ-023 In IDLE, HALT and ERROR, DIN SHALL be 16'h0000 and Run SHALL be 0.

Reset
REQ-024 Resetn=0 SHALL asynchronously force state IDLE, PC=0, din_q=0, imm_q=0, rom_addr=0, DIN=0, Run=0, Busy=0, Halted=0 and Error=0, including mid-instruction.

Configuration
REQ-025 With macro SEQ_TIMEOUT_EN defined, the block SHALL add output Error (out, 1) and a 4-bit watchdog cleared on each Run pulse; after 8 consecutive IMM/WAIT cycles without Done_in it SHALL enter ERROR (Error=1, Busy=0), and ERROR SHALL exit only by Start (to FETCH from PC=0, Error<=0) or reset.
REQ-026 Without SEQ_TIMEOUT_EN, the block SHALL have no Error port, no watchdog and no ERROR state, and WAIT SHALL wait indefinitely.

Verification
REQ-027 ROM[0]=16'h000A (mv R1,R2), ROM[1]=16'h01C0 (halt); Start pulse; Done_in one cycle after Run -> exactly one Run pulse with DIN=16'h000A, PC=1, then Halted=1 and Busy=0.
REQ-028 ROM[0]=16'h0058 (mvi R3), ROM[1]=16'h1234, ROM[2]=16'h01C0; Done_in asserted in IMM -> DIN=16'h0058 during Run, DIN=16'h1234 the next cycle, PC advances to 2, then HALT.
REQ-029 ROM[31]=16'h0058, ROM[0]=16'h00AB; PC forced to 31 by the preceding program -> rom_addr=0 in DECODE, DIN=16'h00AB in IMM, PC wraps to 1.
REQ-030 Resetn pulsed low during WAIT of an add (16'h008B) -> all outputs 0 immediately, state IDLE; a later Start re-executes from address 0.
REQ-031 With SEQ_TIMEOUT_EN, Done_in held 0 after Run -> Error=1 on the 8th WAIT cycle and Run stays 0; Start -> Error=0 and fetch from address 0.
REQ-032 Start held high for 3 cycles during WAIT, then Done_in pulse -> no restart, PC increments by 1 only.

Source files
------------

// File: rtl/program_sequencer.sv
// program_sequencer
//
// Fetches instruction words from a synchronous 32-word ROM and issues them
// to a simple processor one at a time. Each instruction gets a one-cycle Run
// strobe with the instruction word on DIN. An mvi instruction also gets its
// immediate word, which is driven on the cycle after Run. The sequencer then
// waits for the processor's Done pulse before it fetches the next word.
//
// Ports
//   Clock     in   rising-edge clock shared with the processor
//   Resetn    in   asynchronous active-low reset
//   Start     in   start execution at address 0 (honoured in IDLE/HALT/ERROR)
//   Done_in   in   instruction-complete pulse from the processor
//   rom_data  in   ROM read data, one cycle after rom_addr
//   rom_addr  out  ROM word address
//   DIN       out  instruction / immediate word to the processor
//   Run       out  one-cycle instruction-issue strobe
//   Busy      out  high while a program is executing
//   Halted    out  high in HALT
//   Error     out  high in ERROR (only with SEQ_TIMEOUT_EN)
//
// Build option
//   SEQ_TIMEOUT_EN  adds the Error port, a watchdog and the ERROR state. After
//                   8 consecutive IMM/WAIT cycles without Done_in, the
//                   sequencer enters ERROR.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | out of reset, waiting for Start
// FETCH  | rom_addr = PC, instruction word arrives next cycle
// DECODE | latch instruction; halt -> HALT, mvi prefetches PC+1
// RUN    | Run strobe with instruction word; mvi latches immediate
// IMM    | immediate word on DIN (mvi only)
// WAIT   | wait for Done_in, then advance PC
// HALT   | halt instruction reached, waiting for Start
// ERROR  | watchdog expired, waiting for Start (SEQ_TIMEOUT_EN only)

module program_sequencer (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic        Done_in,
  input  logic [15:0] rom_data,
  output logic [4:0]  rom_addr,
  output logic [15:0] DIN,
  output logic        Run,
  output logic        Busy,
  output logic        Halted
`ifdef SEQ_TIMEOUT_EN
  ,
  output logic        Error
`endif
);

  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

`ifdef SEQ_TIMEOUT_EN
  // The watchdog counts from 0. The eighth silent cycle is the one seen
  // with count 7.
  localparam logic [3:0] WDOG_LAST = 4'd7;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_RUN    = 3'd3,
    S_IMM    = 3'd4,
    S_WAIT   = 3'd5,
    S_HALT   = 3'd6
`ifdef SEQ_TIMEOUT_EN
    ,
    S_ERROR  = 3'd7
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  pc_q, pc_d;
  logic [15:0] din_q, din_d;
  logic [15:0] imm_q, imm_d;
  logic        mvi_q, mvi_d;
  // Last value driven on DIN, used wherever DIN must hold.
  logic [15:0] din_hold_q;

`ifdef SEQ_TIMEOUT_EN
  logic [3:0]  wdog_q, wdog_d;
`endif

  logic [2:0]  rom_op;
  assign rom_op = rom_data[8:6];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      din_q      <= '0;
      imm_q      <= '0;
      mvi_q      <= 1'b0;
      din_hold_q <= '0;
`ifdef SEQ_TIMEOUT_EN
      wdog_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      din_q      <= din_d;
      imm_q      <= imm_d;
      mvi_q      <= mvi_d;
      din_hold_q <= DIN;
`ifdef SEQ_TIMEOUT_EN
      wdog_q     <= wdog_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    din_d    = din_q;
    imm_d    = imm_q;
    mvi_d    = mvi_q;
`ifdef SEQ_TIMEOUT_EN
    wdog_d   = wdog_q;
`endif
    rom_addr = pc_q;
    DIN      = din_hold_q;
    Run      = 1'b0;
    Busy     = 1'b1;
    Halted   = 1'b0;

    case (state_q)
      S_IDLE, S_HALT: begin
        Busy   = 1'b0;
        Halted = (state_q == S_HALT);
        DIN    = 16'h0000;
        if (Start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        state_d = S_DECODE;
      end

      S_DECODE: begin
        din_d = rom_data;
        mvi_d = (rom_op == OP_MVI);
        // Present the immediate's address now so the word arrives during RUN.
        if (rom_op == OP_MVI) begin
          rom_addr = pc_q + 5'd1;
        end
        if (rom_op == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        Run = 1'b1;
        DIN = din_q;
`ifdef SEQ_TIMEOUT_EN
        wdog_d = '0;
`endif
        if (mvi_q) begin
          imm_d   = rom_data;
          state_d = S_IMM;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_IMM: begin
        DIN = imm_q;
        if (Done_in) begin
          pc_d    = pc_q + 5'd2;
          state_d = S_FETCH;
        end else begin
          state_d = S_WAIT;
`ifdef SEQ_TIMEOUT_EN
          wdog_d = wdog_q + 4'd1;
          if (wdog_q == WDOG_LAST) begin
            state_d = S_ERROR;
          end
`endif
        end
      end

      S_WAIT: begin
        if (Done_in) begin
          pc_d    = pc_q + (mvi_q ? 5'd2 : 5'd1);
          state_d = S_FETCH;
        end else begin
`ifdef SEQ_TIMEOUT_EN
          wdog_d = wdog_q + 4'd1;
          if (wdog_q == WDOG_LAST) begin
            state_d = S_ERROR;
          end
`endif
        end
      end

`ifdef SEQ_TIMEOUT_EN
      S_ERROR: begin
        Busy = 1'b0;
        DIN  = 16'h0000;
        if (Start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef SEQ_TIMEOUT_EN
  assign Error = (state_q == S_ERROR);
`endif

endmodule

// File: tb/tb_program_sequencer.sv
module tb_program_sequencer;

  logic        Clock;
  logic        Resetn;
  logic        Start;
  logic        Done_in;
  logic [15:0] rom_data;
  logic [4:0]  rom_addr;
  logic [15:0] DIN;
  logic        Run;
  logic        Busy;
  logic        Halted;
`ifdef SEQ_TIMEOUT_EN
  logic        Error;
`endif

  program_sequencer dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .Start    (Start),
    .Done_in  (Done_in),
    .rom_data (rom_data),
    .rom_addr (rom_addr),
    .DIN      (DIN),
    .Run      (Run),
    .Busy     (Busy),
    .Halted   (Halted)
`ifdef SEQ_TIMEOUT_EN
    ,
    .Error    (Error)
`endif
  );

  localparam logic [15:0] HALT_W = 16'h01C0;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Synchronous ROM model.
  logic [15:0] rom [32];
  always @(posedge Clock) rom_data <= rom[rom_addr];

  typedef struct {
    logic [15:0] din;
    bit          mvi;
    logic [15:0] imm;
  } exp_t;

  typedef struct {
    logic [15:0] instr;
    bit          has_imm;
    logic [15:0] imm;
    int          dly;
    int          exp_runs;
    logic [4:0]  exp_pc;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[7];
  int   n_cmp = 0;
  int   n_err = 0;
  int   run_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event did not occur within its cycle budget", name);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic fill_rom(input logic [15:0] w);
    for (int a = 0; a < 32; a++) rom[a] = w;
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    Start = 1'b0;
    Done_in = 1'b0;
    tick();
    tick();
    Resetn = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // Advances until Run is seen, remembering rom_addr in the cycle before Run (DECODE).
  task automatic wait_run(output logic [4:0] dec_addr, output bit ok);
    ok = 1'b0;
    dec_addr = '0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (Run) begin
        ok = 1'b1;
        break;
      end
      dec_addr = rom_addr;
    end
  endtask

  task automatic wait_halt();
    int n;
    n = 0;
    while (!Halted && n < 30) begin
      tick();
      n++;
    end
    if (!Halted) fail("halt_timeout");
  endtask

  // Issues one instruction and pulses Done_in dly cycles after Run.
  task automatic exec_instr(input logic [15:0] din, input bit mvi, input logic [15:0] imm,
                            input int dly, input logic [4:0] exp_dec, input logic [4:0] exp_next);
    exp_t e;
    logic [4:0] dec;
    bit ok;
    e.din = din;
    e.mvi = mvi;
    e.imm = imm;
    sb_q.push_back(e);
    wait_run(dec, ok);
    if (!ok) begin
      fail("run_timeout");
      return;
    end
    chk("decode_addr", dec, exp_dec);
    repeat (dly) tick();
    chk("hold_din", DIN, mvi ? imm : din);
    Done_in = 1'b1;
    tick();
    Done_in = 1'b0;
    chk("next_pc", rom_addr, exp_next);
  endtask

  // Scoreboard consumer: checks DIN on each Run and on the immediate cycle.
  initial begin
    exp_t e;
    bit pend;
    logic [15:0] pimm;
    pend = 1'b0;
    pimm = '0;
    forever begin
      @(negedge Clock);
      if (!Resetn) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("imm_din", DIN, pimm);
          pend = 1'b0;
        end
        if (Run) begin
          run_count++;
          if (sb_q.size() == 0) begin
            fail("unexpected_run");
          end else begin
            e = sb_q.pop_front();
            chk("run_din", DIN, e.din);
            if (e.mvi) begin
              pend = 1'b1;
              pimm = e.imm;
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [4:0] dec;
    bit ok;
    exp_t e;
    int r0;

    //          instr     imm?  imm       dly runs pc
    vecs[0] = '{16'h000A, 1'b0, 16'h0000, 1,  1,   5'd1};
    vecs[1] = '{16'h0058, 1'b1, 16'h1234, 1,  1,   5'd2};
    vecs[2] = '{16'h0058, 1'b1, 16'h5555, 3,  1,   5'd2};
    vecs[3] = '{16'h008B, 1'b0, 16'h0000, 4,  1,   5'd1};
    vecs[4] = '{16'h01C0, 1'b0, 16'h0000, 1,  0,   5'd0};
    vecs[5] = '{16'h0040, 1'b1, 16'hAAAA, 2,  1,   5'd2};
    vecs[6] = '{16'h0180, 1'b0, 16'h0000, 2,  1,   5'd1};

    Resetn = 1'b0;
    Start = 1'b0;
    Done_in = 1'b0;
    fill_rom(HALT_W);
    tick();
    tick();
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_din", DIN, 0);
    chk("rst_run", Run, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_halted", Halted, 0);
`ifdef SEQ_TIMEOUT_EN
    chk("rst_error", Error, 0);
`endif
    Resetn = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      fill_rom(HALT_W);
      rom[0] = vecs[v].instr;
      if (vecs[v].has_imm) rom[1] = vecs[v].imm;
      do_reset();
      r0 = run_count;
      pulse_start();
      chk("start_busy", Busy, 1);
      if (vecs[v].exp_runs != 0)
        exec_instr(vecs[v].instr, vecs[v].has_imm, vecs[v].imm, vecs[v].dly,
                   vecs[v].has_imm ? 5'd1 : 5'd0, vecs[v].exp_pc);
      wait_halt();
      chk("vec_pc", rom_addr, vecs[v].exp_pc);
      chk("vec_busy", Busy, 0);
      chk("vec_halted", Halted, 1);
      chk("vec_runs", run_count - r0, vecs[v].exp_runs);
    end

    // PC wrap: an add at 0, mvi pairs at 1..30, then an mvi at 31 whose immediate is ROM[0].
    fill_rom(HALT_W);
    rom[0] = 16'h00AB;
    for (int a = 1; a <= 29; a += 2) begin
      rom[a] = 16'h0058;
      rom[a + 1] = 16'(16'h1100 + a + 1);
    end
    rom[31] = 16'h0058;
    do_reset();
    pulse_start();
    exec_instr(16'h00AB, 1'b0, 16'h0000, 1, 5'd0, 5'd1);
    for (int a = 1; a <= 29; a += 2)
      exec_instr(16'h0058, 1'b1, 16'(16'h1100 + a + 1), 1, 5'(a + 1), 5'(a + 2));
    exec_instr(16'h0058, 1'b1, 16'h00AB, 2, 5'd0, 5'd1);
    chk("wrap_sb_drained", sb_q.size(), 0);

    // Reset pulsed during WAIT of an add, then re-execute from 0.
    fill_rom(HALT_W);
    rom[0] = 16'h000A;
    rom[1] = 16'h008B;
    do_reset();
    pulse_start();
    exec_instr(16'h000A, 1'b0, 16'h0000, 1, 5'd0, 5'd1);
    e.din = 16'h008B;
    e.mvi = 1'b0;
    e.imm = '0;
    sb_q.push_back(e);
    wait_run(dec, ok);
    if (!ok) fail("rst_run_timeout");
    tick();
    tick();
    chk("wait_busy", Busy, 1);
    chk("wait_din", DIN, 16'h008B);
    Resetn = 1'b0;
    #1;
    chk("arst_rom_addr", rom_addr, 0);
    chk("arst_din", DIN, 0);
    chk("arst_run", Run, 0);
    chk("arst_busy", Busy, 0);
    chk("arst_halted", Halted, 0);
    tick();
    Resetn = 1'b1;
    tick();
    pulse_start();
    exec_instr(16'h000A, 1'b0, 16'h0000, 1, 5'd0, 5'd1);
    exec_instr(16'h008B, 1'b0, 16'h0000, 3, 5'd1, 5'd2);
    wait_halt();
    chk("rerun_pc", rom_addr, 2);

    // Start held during WAIT is ignored; Done in HALT is ignored.
    fill_rom(HALT_W);
    rom[0] = 16'h000A;
    do_reset();
    r0 = run_count;
    pulse_start();
    e.din = 16'h000A;
    sb_q.push_back(e);
    wait_run(dec, ok);
    if (!ok) fail("busy_run_timeout");
    tick();
    Start = 1'b1;
    repeat (3) tick();
    Start = 1'b0;
    chk("busy_start_busy", Busy, 1);
    chk("busy_start_pc", rom_addr, 0);
    Done_in = 1'b1;
    tick();
    Done_in = 1'b0;
    chk("busy_start_next", rom_addr, 1);
    wait_halt();
    chk("busy_start_final_pc", rom_addr, 1);
    chk("busy_start_runs", run_count - r0, 1);
    Done_in = 1'b1;
    tick();
    Done_in = 1'b0;
    tick();
    chk("halt_done_halted", Halted, 1);
    chk("halt_done_pc", rom_addr, 1);

`ifdef SEQ_TIMEOUT_EN
    // Watchdog: no Done after Run -> ERROR after 8 WAIT cycles; Start recovers.
    fill_rom(HALT_W);
    rom[0] = 16'h000A;
    do_reset();
    pulse_start();
    e.din = 16'h000A;
    sb_q.push_back(e);
    wait_run(dec, ok);
    if (!ok) fail("wd_run_timeout");
    repeat (8) tick();
    chk("wd_error_early", Error, 0);
    chk("wd_busy_early", Busy, 1);
    tick();
    chk("wd_error", Error, 1);
    chk("wd_busy", Busy, 0);
    chk("wd_run", Run, 0);
    chk("wd_din", DIN, 0);
    repeat (3) tick();
    chk("wd_error_stays", Error, 1);
    pulse_start();
    chk("wd_error_clear", Error, 0);
    chk("wd_fetch_addr", rom_addr, 0);
    exec_instr(16'h000A, 1'b0, 16'h0000, 1, 5'd0, 5'd1);
    wait_halt();
    chk("wd_final_halted", Halted, 1);
`endif

    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
